algorithm_multi_vc: RTL



---
 rtl/algorithm_multi_vc_if.sv | 42 ++++
 rtl/algorithm_multi_vc.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/algorithm_multi_vc_if.sv
// Stream bundle for one router input port and its fan-out of output channels.
//   in_*  : single upstream AXI-Stream (tvalid/tready/tdata/tid/tdest/tuser/tlast)
//   out_* : CHANNEL_NUMBER downstream streams, packed per channel
// master : upstream source / downstream sinks (drives in_* payload, out_tready)
// slave  : the routing stage (drives in_tready and all out_* payload)
interface algorithm_multi_vc_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int DEST_WIDTH     = 4,
    parameter int USER_WIDTH     = 4,
    parameter int CHANNEL_NUMBER = 10
);
    logic                                       in_tvalid;
    logic                                       in_tready;
    logic [DATA_WIDTH-1:0]                      in_tdata;
    logic [ID_WIDTH-1:0]                        in_tid;
    logic [DEST_WIDTH-1:0]                      in_tdest;
    logic [USER_WIDTH-1:0]                      in_tuser;
    logic                                       in_tlast;

    logic [CHANNEL_NUMBER-1:0]                  out_tvalid;
    logic [CHANNEL_NUMBER-1:0]                  out_tready;
    logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0]  out_tdata;
    logic [CHANNEL_NUMBER-1:0][ID_WIDTH-1:0]    out_tid;
    logic [CHANNEL_NUMBER-1:0][DEST_WIDTH-1:0]  out_tdest;
    logic [CHANNEL_NUMBER-1:0][USER_WIDTH-1:0]  out_tuser;
    logic [CHANNEL_NUMBER-1:0]                  out_tlast;

    modport master (
        output in_tvalid, in_tdata, in_tid, in_tdest, in_tuser, in_tlast,
        input  in_tready,
        input  out_tvalid, out_tdata, out_tid, out_tdest, out_tuser, out_tlast,
        output out_tready
    );

    modport slave (
        input  in_tvalid, in_tdata, in_tid, in_tdest, in_tuser, in_tlast,
        output in_tready,
        output out_tvalid, out_tdata, out_tid, out_tdest, out_tuser, out_tlast,
        input  out_tready
    );
endinterface

// File: rtl/algorithm_multi_vc.sv
// Per-input routing/demux stage of the mesh router.
// Steers the input stream onto one of 5*VC_NUMBER output channels using
// dimension-ordered routing (XY or YX), holds the route for a whole packet,
// and keeps saturating per-channel header counters.
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   axis               stream bundle (slave view): input stream + output channels
//   target_x_i/y_i     destination coordinates, valid with the header beat
//   in_vc_i            VC class of the packet, sampled on the header beat
//   cnt_clr_i          synchronous clear of all packet counters
//   locked_o           route lock held (mid-packet)
//   locked_channel_o   locked channel index, 0 when unlocked
//   pkt_count_o        header handshakes per channel, saturating
//
// state  | meaning
// IDLE   | no packet in flight; route computed from target/in_vc each cycle
// LOCKED | header accepted, beats follow the locked channel until TLAST
module algorithm_multi_vc #(
    parameter int DATA_WIDTH           = 32,
    parameter int ID_WIDTH             = 4,
    parameter int DEST_WIDTH           = 4,
    parameter int USER_WIDTH           = 4,
    parameter int VC_NUMBER            = 2,
    parameter int CHANNEL_NUMBER       = 5 * VC_NUMBER,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int VC_WIDTH             = (VC_NUMBER > 1) ? $clog2(VC_NUMBER) : 1,
    parameter int MAX_ROUTERS_X        = 4,
    parameter int MAX_ROUTERS_Y        = 4,
    parameter int MAX_ROUTERS_X_WIDTH  = $clog2(MAX_ROUTERS_X),
    parameter int MAX_ROUTERS_Y_WIDTH  = $clog2(MAX_ROUTERS_Y),
    parameter int ROUTER_X             = 0,
    parameter int ROUTER_Y             = 0,
    parameter int ROUTING_MODE         = 0,
    parameter int COUNTER_WIDTH        = 16,
    parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '0
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    algorithm_multi_vc_if.slave                           axis,
    input  logic [MAX_ROUTERS_X_WIDTH-1:0]                target_x_i,
    input  logic [MAX_ROUTERS_Y_WIDTH-1:0]                target_y_i,
    input  logic [VC_WIDTH-1:0]                           in_vc_i,
    input  logic                                          cnt_clr_i,
    output logic                                          locked_o,
    output logic [CHANNEL_NUMBER_WIDTH-1:0]               locked_channel_o,
    output logic [CHANNEL_NUMBER-1:0][COUNTER_WIDTH-1:0]  pkt_count_o
);

    localparam logic [2:0] DIR_LOCAL = 3'd0;
    localparam logic [2:0] DIR_NORTH = 3'd1;
    localparam logic [2:0] DIR_EAST  = 3'd2;
    localparam logic [2:0] DIR_SOUTH = 3'd3;
    localparam logic [2:0] DIR_WEST  = 3'd4;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                           state, next_state;
    logic [CHANNEL_NUMBER_WIDTH-1:0]  lock_ch, next_lock_ch;
    logic [CHANNEL_NUMBER_WIDTH-1:0]  computed_ch;
    logic [CHANNEL_NUMBER_WIDTH-1:0]  ctrl;
    logic [2:0]                       dir;
    logic [VC_WIDTH-1:0]              vc;
    logic                             handshake;
    logic                             is_header;
    logic                             count_inc;

    // Coordinates compared as int so that edge routers (e.g. X=0) do not
    // produce constant-result unsigned comparisons.
    always_comb begin
        dir = DIR_LOCAL;
        if (ROUTING_MODE == 0) begin
            if (int'(target_x_i) > ROUTER_X)      dir = DIR_EAST;
            else if (int'(target_x_i) < ROUTER_X) dir = DIR_WEST;
            else if (int'(target_y_i) < ROUTER_Y) dir = DIR_NORTH;
            else if (int'(target_y_i) > ROUTER_Y) dir = DIR_SOUTH;
        end else begin
            if (int'(target_y_i) < ROUTER_Y)      dir = DIR_NORTH;
            else if (int'(target_y_i) > ROUTER_Y) dir = DIR_SOUTH;
            else if (int'(target_x_i) > ROUTER_X) dir = DIR_EAST;
            else if (int'(target_x_i) < ROUTER_X) dir = DIR_WEST;
        end
    end

    // Out-of-range VC classes (non power-of-two VC_NUMBER) fold onto the top VC.
    always_comb begin
        vc = in_vc_i;
        if (int'(in_vc_i) > VC_NUMBER - 1) vc = VC_WIDTH'(VC_NUMBER - 1);
    end

    assign computed_ch = CHANNEL_NUMBER_WIDTH'(int'(dir) * VC_NUMBER + int'(vc));

    // Holding the route in the register is what makes mid-packet header-TID
    // beats and target changes harmless.
    assign ctrl      = (state == LOCKED) ? lock_ch : computed_ch;
    assign handshake = axis.in_tvalid & axis.out_tready[ctrl];
    assign is_header = (axis.in_tid == ROUTING_HEADER);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else begin
            state   <= next_state;
            lock_ch <= next_lock_ch;
        end
    end

    always_comb begin
        next_state   = state;
        next_lock_ch = lock_ch;
        count_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (handshake && is_header) begin
                    count_inc = 1'b1;
                    // Single-beat packets never take the lock.
                    if (!axis.in_tlast) begin
                        next_state   = LOCKED;
                        next_lock_ch = computed_ch;
                    end
                end
            end
            LOCKED: begin
                if (handshake && axis.in_tlast) begin
                    next_state   = IDLE;
                    next_lock_ch = '0;
                end
            end
            default: begin
                next_state   = IDLE;
                next_lock_ch = '0;
            end
        endcase
    end

    assign locked_o         = (state == LOCKED);
    assign locked_channel_o = lock_ch;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_count_o <= '0;
        end else begin
            for (int c = 0; c < CHANNEL_NUMBER; c++) begin
                if (cnt_clr_i) begin
                    pkt_count_o[c] <= '0;
                end else if (count_inc && (ctrl == CHANNEL_NUMBER_WIDTH'(c))
                             && (pkt_count_o[c] != '1)) begin
                    pkt_count_o[c] <= pkt_count_o[c] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        axis.out_tvalid       = '0;
        axis.out_tdata        = '0;
        axis.out_tid          = '0;
        axis.out_tdest        = '0;
        axis.out_tuser        = '0;
        axis.out_tlast        = '0;
        axis.out_tvalid[ctrl] = axis.in_tvalid;
        axis.out_tdata[ctrl]  = axis.in_tdata;
        axis.out_tid[ctrl]    = axis.in_tid;
        axis.out_tdest[ctrl]  = axis.in_tdest;
        axis.out_tuser[ctrl]  = axis.in_tuser;
        axis.out_tlast[ctrl]  = axis.in_tlast;
        axis.in_tready        = axis.out_tready[ctrl];
    end

endmodule
